alu_bus_sequencer: RTL and testbench

Host-side driver for the datapath's enable/data load protocol. It accepts one ALU command per valid/ready handshake and drives the two-bit enable and eight-bit data bus that feed the register/ALU controller. The driving order is operand loads, then instruction load, then execute. The sequencer captures the controller's result bus and flags at the execute edge and returns them through a valid/ready response port. It sits between a command source (test host or future fetch unit) and the register/ALU controller; it is the initiator for that controller's load/execute protocol.

---
 rtl/alu_bus_sequencer_if.sv | 45 ++++
 rtl/alu_bus_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_bus_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_bus_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_bus_sequencer_if
// Bundles the three signal groups around the ALU bus sequencer:
//   cmd_* : command port (source -> sequencer), valid/ready
//   rsp_* : response port (sequencer -> consumer), valid/ready
//   ctl_* : load/execute bus to the register/ALU controller
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Once valid is raised, the sender keeps it high and its
// payload stable until that transfer edge.
// Modports:
//   master : the sequencer itself (initiator of the controller protocol)
//   slave  : the environment (command source, response consumer, controller)
// -----------------------------------------------------------------------------
interface alu_bus_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_sel1;
  logic       cmd_sel0;
  logic [1:0] cmd_dst;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_keep_r0;
  logic       cmd_keep_r1;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_flags;
  logic [1:0] ctl_enable;
  logic [7:0] ctl_data;
  logic [7:0] ctl_result;
  logic [7:0] ctl_ir;

  modport master (
    input  cmd_valid, cmd_op, cmd_sel1, cmd_sel0, cmd_dst, cmd_a, cmd_b,
           cmd_keep_r0, cmd_keep_r1, rsp_ready, ctl_result, ctl_ir,
    output cmd_ready, rsp_valid, rsp_data, rsp_flags, ctl_enable, ctl_data
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_sel1, cmd_sel0, cmd_dst, cmd_a, cmd_b,
           cmd_keep_r0, cmd_keep_r1, rsp_ready, ctl_result, ctl_ir,
    input  cmd_ready, rsp_valid, rsp_data, rsp_flags, ctl_enable, ctl_data
  );
endinterface

// File: rtl/alu_bus_sequencer.sv
// -----------------------------------------------------------------------------
// alu_bus_sequencer
// Accepts one ALU command per handshake and walks the register/ALU controller
// through operand loads, instruction load and one execute cycle, then returns
// the result/flags captured at the end of that execute cycle.
// Ports:
//   clk         : system clock (sequencer on posedge, controller on negedge)
//   rst_n       : asynchronous active-low reset
//   bus         : alu_bus_if.master (cmd_*, rsp_*, ctl_* groups)
//   o_dbg_state : current FSM state, for observation only
// -----------------------------------------------------------------------------
module alu_bus_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  alu_bus_if.master  bus,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_R0 = 3'd1,
    S_LOAD_R1 = 3'd2,
    S_LOAD_IR = 3'd3,
    S_EXEC    = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t     r_state, w_next_state;
  logic [1:0] r_enable, w_next_enable;
  logic [7:0] r_data, w_next_data;
  logic       w_accept;

  // Latched command fields. The R0 value and keep_r0 flag are consumed on the
  // accepting edge itself (LOAD_R0 only ever follows IDLE), so they need no
  // storage.
  logic [7:0] r_b;
  logic [1:0] r_op;
  logic       r_sel1;
  logic       r_sel0;
  logic [1:0] r_dst;
  logic       r_keep_r1;

  logic [7:0] r_rsp_data;
  logic [1:0] r_rsp_flags;

  logic [7:0] w_cmd_ir;
  logic [7:0] w_lat_ir;

  assign w_cmd_ir = {2'b00, bus.cmd_op, bus.cmd_sel1, bus.cmd_sel0, bus.cmd_dst};
  assign w_lat_ir = {2'b00, r_op, r_sel1, r_sel0, r_dst};

  // Next state and the next value of the registered ctl_* outputs are decided
  // together, so ctl_enable/ctl_data always line up with the state they belong to.
  always_comb begin
    w_next_state  = r_state;
    w_next_enable = 2'b00;
    w_next_data   = r_data;
    w_accept      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_accept = 1'b1;
          if (!bus.cmd_keep_r0) begin
            w_next_state  = S_LOAD_R0;
            w_next_enable = 2'b01;
            w_next_data   = bus.cmd_a;
          end else if (!bus.cmd_keep_r1) begin
            w_next_state  = S_LOAD_R1;
            w_next_enable = 2'b10;
            w_next_data   = bus.cmd_b;
          end else begin
            w_next_state  = S_LOAD_IR;
            w_next_enable = 2'b11;
            w_next_data   = w_cmd_ir;
          end
        end
      end
      S_LOAD_R0: begin
        if (!r_keep_r1) begin
          w_next_state  = S_LOAD_R1;
          w_next_enable = 2'b10;
          w_next_data   = r_b;
        end else begin
          w_next_state  = S_LOAD_IR;
          w_next_enable = 2'b11;
          w_next_data   = w_lat_ir;
        end
      end
      S_LOAD_R1: begin
        w_next_state  = S_LOAD_IR;
        w_next_enable = 2'b11;
        w_next_data   = w_lat_ir;
      end
      S_LOAD_IR: w_next_state = S_EXEC;
      S_EXEC:    w_next_state = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) w_next_state = S_IDLE;
      end
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_enable <= 2'b00;
      r_data   <= 8'h00;
    end else begin
      r_state  <= w_next_state;
      r_enable <= w_next_enable;
      r_data   <= w_next_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b       <= 8'h00;
      r_op      <= 2'b00;
      r_sel1    <= 1'b0;
      r_sel0    <= 1'b0;
      r_dst     <= 2'b00;
      r_keep_r1 <= 1'b0;
    end else if (w_accept) begin
      r_b       <= bus.cmd_b;
      r_op      <= bus.cmd_op;
      r_sel1    <= bus.cmd_sel1;
      r_sel0    <= bus.cmd_sel0;
      r_dst     <= bus.cmd_dst;
      r_keep_r1 <= bus.cmd_keep_r1;
    end
  end

  // Capture only on the edge leaving EXEC: later execute cycles recompute from
  // written-back registers, so the controller's result bus goes stale after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data  <= 8'h00;
      r_rsp_flags <= 2'b00;
    end else if (r_state == S_EXEC) begin
      r_rsp_data  <= bus.ctl_result;
      r_rsp_flags <= bus.ctl_ir[7:6];
    end
  end

  assign bus.cmd_ready  = (r_state == S_IDLE);
  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_flags  = r_rsp_flags;
  assign bus.ctl_enable = r_enable;
  assign bus.ctl_data   = r_data;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_bus_sequencer
// Drives alu_bus_sequencer against a negedge-sampling register/ALU controller
// emulation. Expected bus sequences and results come from a transaction-level
// register model (m_r0/m_r1) updated once per command.
// ALU used by the controller emulation and the model:
//   op 00 add, 01 sub, 10 and, 11 xor; flags = {carry/borrow, zero}
// -----------------------------------------------------------------------------
module tb_alu_bus_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  alu_bus_if bus ();

  alu_bus_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- ALU definition ----------------
  function automatic logic [9:0] alu(input logic [1:0] op, input logic [7:0] x,
                                     input logic [7:0] y);
    logic [8:0] t;
    case (op)
      2'b00:   t = {1'b0, x} + {1'b0, y};
      2'b01:   t = {1'b0, x} - {1'b0, y};
      2'b10:   t = {1'b0, x & y};
      default: t = {1'b0, x ^ y};
    endcase
    return {t[8], (t[7:0] == 8'h00), t[7:0]};
  endfunction

  // ---------------- controller emulation (samples on negedge) ----------------
  logic [7:0] c_r0 = 8'h00;
  logic [7:0] c_r1 = 8'h00;
  logic [7:0] c_ir = 8'h00;
  logic [7:0] c_res = 8'h00;
  logic [9:0] c_tmp;

  assign bus.ctl_result = c_res;
  assign bus.ctl_ir     = c_ir;

  always @(negedge clk) begin
    case (bus.ctl_enable)
      2'b01: c_r0 <= bus.ctl_data;
      2'b10: c_r1 <= bus.ctl_data;
      2'b11: c_ir <= bus.ctl_data;
      default: begin
        c_tmp = alu(c_ir[5:4], c_ir[2] ? c_r1 : c_r0, c_ir[3] ? c_r1 : c_r0);
        c_res <= c_tmp[7:0];
        c_ir  <= {c_tmp[9:8], c_ir[5:2], 2'b00};
        if (c_ir[0]) c_r0 <= c_tmp[7:0];
        if (c_ir[1]) c_r1 <= c_tmp[7:0];
      end
    endcase
  end

  // ---------------- transaction-level reference model ----------------
  logic [7:0] m_r0 = 8'h00;
  logic [7:0] m_r1 = 8'h00;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_cmd();
    bus.cmd_a       = 8'($urandom);
    bus.cmd_b       = 8'($urandom);
    bus.cmd_op      = 2'($urandom);
    bus.cmd_sel1    = 1'($urandom);
    bus.cmd_sel0    = 1'($urandom);
    bus.cmd_dst     = 2'($urandom);
    bus.cmd_keep_r0 = 1'($urandom);
    bus.cmd_keep_r1 = 1'($urandom);
  endtask

  // One full command: accept, per-cycle bus check, response check, optional
  // backpressure, response handshake. abort asserts reset during LOAD_IR.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic sel1, input logic sel0,
                         input logic [1:0] dst, input logic k0, input logic k1,
                         input int hold, input bit abort);
    logic [9:0] exp_q[$];
    logic [9:0] e;
    logic [9:0] r;
    logic [7:0] ir;
    int         lat;
    ir = {2'b00, op, sel1, sel0, dst};
    if (!k0) exp_q.push_back({2'b01, a});
    if (!k1) exp_q.push_back({2'b10, b});
    exp_q.push_back({2'b11, ir});
    exp_q.push_back({2'b00, ir});
    lat = exp_q.size();

    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_sel1 = sel1;
    bus.cmd_sel0 = sel0; bus.cmd_dst = dst; bus.cmd_keep_r0 = k0; bus.cmd_keep_r1 = k1;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    scramble_cmd();

    for (int i = 0; i < lat; i++) begin
      e = exp_q.pop_front();
      chk("ctl_enable_seq", 32'(bus.ctl_enable), 32'(e[9:8]));
      chk("ctl_data_seq", 32'(bus.ctl_data), 32'(e[7:0]));
      chk("rsp_valid_busy", 32'(bus.rsp_valid), 32'd0);
      chk("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
      if (abort && e[9:8] == 2'b11) begin
        rst_n = 1'b0;
        #1;
        chk("abort_ctl_enable", 32'(bus.ctl_enable), 32'd0);
        chk("abort_ctl_data", 32'(bus.ctl_data), 32'd0);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("abort_rsp_valid_after", 32'(bus.rsp_valid), 32'd0);
        chk("abort_cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
        chk("abort_ctl_enable_after", 32'(bus.ctl_enable), 32'd0);
        return;
      end
      step();
    end

    // Reference: registers as seen by this command, one execute, writeback.
    if (!k0) m_r0 = a;
    if (!k1) m_r1 = b;
    r = alu(op, sel0 ? m_r1 : m_r0, sel1 ? m_r1 : m_r0);
    if (dst[0]) m_r0 = r[7:0];
    if (dst[1]) m_r1 = r[7:0];

    chk("rsp_valid_latency", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_data", 32'(bus.rsp_data), 32'(r[7:0]));
    chk("rsp_flags", 32'(bus.rsp_flags), 32'(r[9:8]));
    chk("ctl_enable_resp", 32'(bus.ctl_enable), 32'd0);
    chk("cmd_ready_resp", 32'(bus.cmd_ready), 32'd0);

    for (int h = 0; h < hold; h++) begin
      bus.cmd_valid = (h == 1);
      step();
      bus.cmd_valid = 1'b0;
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rsp_data", 32'(bus.rsp_data), 32'(r[7:0]));
      chk("hold_rsp_flags", 32'(bus.rsp_flags), 32'(r[9:8]));
      chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("hold_ctl_enable", 32'(bus.ctl_enable), 32'd0);
    end

    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("rsp_done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rsp_done_cmd_ready", 32'(bus.cmd_ready), 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    scramble_cmd();

    // Reset held with clock running.
    rst_n = 1'b0;
    step();
    step();
    step();
    chk("reset_ctl_enable", 32'(bus.ctl_enable), 32'd0);
    chk("reset_ctl_data", 32'(bus.ctl_data), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("reset_rsp_flags", 32'(bus.rsp_flags), 32'd0);
    rst_n = 1'b1;
    step();
    chk("release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("release_ctl_enable", 32'(bus.ctl_enable), 32'd0);

    // Full command; dst=01 with sel0=0 also exercises the stale-result window
    // (the next execute would give 8'h0b instead of 8'h08).
    run_cmd(8'h05, 8'h03, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 0, 1'b0);
    // Chaining on the written-back R0.
    run_cmd(8'hee, 8'hdd, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 0, 1'b0);
    // Backpressure for 10 cycles with a stray cmd_valid pulse.
    run_cmd(8'h10, 8'h20, 2'b01, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 10, 1'b0);
    // Single-keep paths.
    run_cmd(8'h7f, 8'h01, 2'b00, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1, 1'b0);
    run_cmd(8'h3c, 8'h55, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 0, 1'b0);
    // Reset during LOAD_IR, then a fresh command completes normally.
    run_cmd(8'haa, 8'h0f, 2'b10, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 0, 1'b1);
    run_cmd(8'h80, 8'h80, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 0, 1'b0);

    // Randomized commands against the reference model.
    for (int n = 0; n < 24; n++) begin
      run_cmd(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
